// File: rtl/appliance_cycle_runner_pkg.sv
// Shared types for the appliance cycle runner: setting width, state encoding
// and the settings snapshot captured from LD_Project when a cycle starts.
package appliance_pkg;

  localparam int W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    HEAT  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic [W-1:0] temp;
    logic [W-1:0] cap;
    logic [W-1:0] fan;
    logic [W-1:0] timer;
  } settings_t;

endpackage

// File: rtl/appliance_cycle_runner_if.sv
// Settings, sensor and actuator bundle between the appliance cycle runner
// (slave) and whoever drives the settings and sensor side (master).
interface appliance_cycle_runner_if;
  import appliance_pkg::*;

  logic         start;
  logic         abort;
  logic [W-1:0] temp;
  logic [W-1:0] cap;
  logic [W-1:0] fan;
  logic [W-1:0] timer;
  logic [W-1:0] temp_sense;

  logic [2:0]   state;
  logic         busy;
  logic         pump_on;
  logic         heater_on;
  logic         fan_pwm;
  logic         drain_on;
  logic         done;
  logic [W-1:0] time_left;

  modport master (
    output start, abort, temp, cap, fan, timer, temp_sense,
    input  state, busy, pump_on, heater_on, fan_pwm, drain_on, done, time_left
  );

  modport slave (
    input  start, abort, temp, cap, fan, timer, temp_sense,
    output state, busy, pump_on, heater_on, fan_pwm, drain_on, done, time_left
  );

endinterface

// File: rtl/appliance_cycle_runner_tick_prescaler.sv
// Divides the clock into one-cycle ticks every TICK_DIV cycles; clear restarts
// the count so each state sees its first tick exactly TICK_DIV cycles after entry.
module tick_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/appliance_cycle_runner.sv
// Runs one FILL -> HEAT -> RUN -> DRAIN -> DONE appliance cycle from a snapshot
// of the LD_Project settings, driving pump, heater, fan PWM and drain.
module appliance_cycle_runner
  import appliance_pkg::*;
#(
  parameter int TICK_DIV    = 10,
  parameter int DRAIN_TICKS = 3
) (
  input logic                      clk,
  input logic                      rst_n,
  appliance_cycle_runner_if.slave  bus
);

  state_e       state_q;
  state_e       state_d;
  settings_t    snap_q;
  settings_t    snap_d;
  logic [W-1:0] remain_q;
  logic [W-1:0] remain_d;
  logic [W-1:0] pwmCnt_q;
  logic [W-1:0] pwmCnt_d;

  logic         tick;
  logic         entering;
  logic         lastTick;
  logic         fillDone;
  logic         runDone;

  logic         busyVal;
  logic         pumpVal;
  logic         heaterVal;
  logic         fanVal;
  logic         drainVal;
  logic         doneVal;
  logic [W-1:0] timeLeftVal;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (entering),
    .tick  (tick)
  );

  // A zero-length counted state leaves after its single entry cycle.
  assign lastTick = tick && (remain_q == W'(1));
  assign fillDone = (snap_q.cap == '0) || lastTick;
  assign runDone  = (snap_q.timer == '0) || lastTick;
  assign entering = (state_d != state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FILL;
      end
      FILL: begin
        if (bus.abort)     state_d = DRAIN;
        else if (fillDone) state_d = HEAT;
      end
      HEAT: begin
        if (bus.abort)                            state_d = DRAIN;
        else if (bus.temp_sense >= snap_q.temp)   state_d = RUN;
      end
      RUN: begin
        if (bus.abort)    state_d = DRAIN;
        else if (runDone) state_d = DRAIN;
      end
      DRAIN: begin
        if (lastTick) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FILL loads straight from the bus because the snapshot is written on the same edge.
  always_comb begin
    snap_d = snap_q;
    if ((state_q == IDLE) && bus.start) begin
      snap_d.temp  = bus.temp;
      snap_d.cap   = bus.cap;
      snap_d.fan   = bus.fan;
      snap_d.timer = bus.timer;
    end

    remain_d = remain_q;
    if (entering) begin
      case (state_d)
        FILL:    remain_d = bus.cap;
        RUN:     remain_d = snap_q.timer;
        DRAIN:   remain_d = W'(DRAIN_TICKS);
        default: remain_d = '0;
      endcase
    end else if (tick && (remain_q != '0)) begin
      remain_d = remain_q - 1'b1;
    end

    pwmCnt_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      pwmCnt_d = pwmCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q   <= '0;
      remain_q <= '0;
      pwmCnt_q <= '0;
    end else begin
      snap_q   <= snap_d;
      remain_q <= remain_d;
      pwmCnt_q <= pwmCnt_d;
    end
  end

  always_comb begin
    busyVal     = (state_q != IDLE);
    pumpVal     = (state_q == FILL);
    heaterVal   = (state_q == HEAT);
    fanVal      = (state_q == RUN) && (pwmCnt_q < snap_q.fan);
    drainVal    = (state_q == DRAIN);
    doneVal     = (state_q == DONE);
    timeLeftVal = '0;
    if (state_q == RUN) begin
      timeLeftVal = remain_q;
    end
  end

  assign bus.state     = state_q;
  assign bus.busy      = busyVal;
  assign bus.pump_on   = pumpVal;
  assign bus.heater_on = heaterVal;
  assign bus.fan_pwm   = fanVal;
  assign bus.drain_on  = drainVal;
  assign bus.done      = doneVal;
  assign bus.time_left = timeLeftVal;

endmodule
